// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with valid/ready
// handshake and tag passthrough. Exponent and mantissa widths are parameters.
// Denormal inputs are treated as zero. Underflow flushes to signed zero.
// Overflow saturates to signed infinity.
// Optional macro FMUL_PIPE_RNE_EN: round-to-nearest-even in stage 3.
// When the macro is not defined, the result is truncated.
module fmul_pipe #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW+MW:0]      in_a,
    input  logic [EW+MW:0]      in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW+MW:0]      out_c,
    output logic [TAG_W-1:0]    out_tag
);
    localparam int W  = 1 + EW + MW;
    localparam int XW = EW + 3;          // signed working exponent width
    localparam int PW = 2 * MW + 2;      // full significand product width
    localparam logic        [XW-1:0] BIAS_X = XW'(2 ** (EW - 1) - 1);
    localparam logic signed [XW-1:0] EMAX_X = XW'(2 ** EW - 1);

    // A held result freezes every stage. Bubbles are kept in place and are not collapsed.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 1 registers
    logic              v1_reg, sign1_reg, zero1_reg;
    logic [EW+1:0]     eadd1_reg;
    logic [MW:0]       ma1_reg, mb1_reg;
    logic [TAG_W-1:0]  tag1_reg;

    // Stage 2 registers
    logic              v2_reg, sign2_reg, zero2_reg;
    logic [EW+1:0]     eadd2_reg;
    logic [PW-1:0]     prod2_reg;
    logic [TAG_W-1:0]  tag2_reg;

    // Stage 3 combinational signals
    logic              top;
    logic [MW-1:0]     mant;
    logic [MW-1:0]     mant_fin;
    logic signed [XW-1:0] e_norm;
    logic signed [XW-1:0] e_fin;
    logic [W-1:0]      c_next;
    logic [PW-1:0]     prod_next;

    // Stage 1: unpack the operands, XOR the signs, add the biased exponents, detect zero operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            sign1_reg <= 1'b0;
            zero1_reg <= 1'b0;
            eadd1_reg <= '0;
            ma1_reg   <= '0;
            mb1_reg   <= '0;
            tag1_reg  <= '0;
        end else if (!stall) begin
            v1_reg    <= in_valid;
            sign1_reg <= in_a[W-1] ^ in_b[W-1];
            zero1_reg <= (in_a[W-2:MW] == '0) || (in_b[W-2:MW] == '0);
            eadd1_reg <= {2'b00, in_a[W-2:MW]} + {2'b00, in_b[W-2:MW]};
            ma1_reg   <= {1'b1, in_a[MW-1:0]};
            mb1_reg   <= {1'b1, in_b[MW-1:0]};
            tag1_reg  <= in_tag;
        end
    end

    assign prod_next = {{(MW+1){1'b0}}, ma1_reg} * {{(MW+1){1'b0}}, mb1_reg};

    // Stage 2: multiply the significands, each with its hidden 1 restored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            sign2_reg <= 1'b0;
            zero2_reg <= 1'b0;
            eadd2_reg <= '0;
            prod2_reg <= '0;
            tag2_reg  <= '0;
        end else if (!stall) begin
            v2_reg    <= v1_reg;
            sign2_reg <= sign1_reg;
            zero2_reg <= zero1_reg;
            eadd2_reg <= eadd1_reg;
            prod2_reg <= prod_next;
            tag2_reg  <= tag1_reg;
        end
    end

`ifdef FMUL_PIPE_RNE_EN
    logic          guard, sticky, round_up;
    logic [MW:0]   mant_sum;
`else
    logic          unused_low;
`endif

    // Stage 3: normalise, adjust the exponent, round, then classify and pack the result
    always_comb begin
        top    = prod2_reg[PW-1];
        mant   = top ? prod2_reg[PW-2:MW+1] : prod2_reg[PW-3:MW];
        e_norm = {1'b0, eadd2_reg} - BIAS_X + {{(XW-1){1'b0}}, top};
`ifdef FMUL_PIPE_RNE_EN
        guard    = top ? prod2_reg[MW] : prod2_reg[MW-1];
        sticky   = top ? (|prod2_reg[MW-1:0]) : (|prod2_reg[MW-2:0]);
        round_up = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {{MW{1'b0}}, round_up};
        // A carry out of the mantissa wraps it to zero and increments the exponent.
        mant_fin = mant_sum[MW-1:0];
        e_fin    = e_norm + {{(XW-1){1'b0}}, mant_sum[MW]};
`else
        mant_fin = mant;
        e_fin    = e_norm;
`endif
        if (zero2_reg)
            c_next = {sign2_reg, {(EW+MW){1'b0}}};
        else if (e_fin[XW-1] || (e_fin == '0))
            c_next = {sign2_reg, {(EW+MW){1'b0}}};
        else if (e_fin >= EMAX_X)
            c_next = {sign2_reg, {EW{1'b1}}, {MW{1'b0}}};
        else
            c_next = {sign2_reg, e_fin[EW-1:0], mant_fin};
    end

`ifndef FMUL_PIPE_RNE_EN
    // Truncation never reads the low product bits. They are only used when rounding is enabled.
    assign unused_low = ^prod2_reg[MW-1:0];
`endif

    // Output register: holds the result stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= v2_reg;
            out_c     <= c_next;
            out_tag   <= tag2_reg;
        end
    end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed, table-driven bench for fmul_pipe with EW=8, MW=23 and TAG_W=5.
// It also covers back-pressure ordering and reset while operations are in flight.
module tb_fmul_pipe;
    localparam int EW    = 8;
    localparam int MW    = 23;
    localparam int TAG_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_c;
    logic [TAG_W-1:0]  out_tag;

    int errors = 0;
    int checks = 0;

    fmul_pipe #(.EW(EW), .MW(MW), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [TAG_W-1:0]  tag;
        logic [31:0]       c;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One isolated operation: checks exact 3-cycle latency, the result and the tag echo.
    task automatic run_one(input vec_t v);
        chk({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_tag = v.tag;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        chk({v.name, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, "_lat2"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({v.name, "_c"}, out_c, v.c);
        chk({v.name, "_tag"}, {27'd0, out_tag}, {27'd0, v.tag});
        $display("op %s: a=%h b=%h -> c=%h tag=%0d (want %h tag=%0d)",
                 v.name, v.a, v.b, out_c, out_tag, v.c, v.tag);
        @(posedge clk); #1;
    endtask

    logic [31:0]       sa[4], sb[4], sc[4];
    logic [TAG_W-1:0]  st[4];
    int                got;
    logic              accept_now;

    initial begin
        vecs[0]  = '{"two_x_three",   32'h40000000, 32'h40400000, 5'd3,  32'h40C00000};
        vecs[1]  = '{"neg_norm",      32'hBFC00000, 32'h3FC00000, 5'd17, 32'hC0100000};
        vecs[2]  = '{"zero_x_max",    32'h00000000, 32'h7F7FFFFF, 5'd5,  32'h00000000};
        vecs[3]  = '{"overflow",      32'h7F000000, 32'h7F000000, 5'd9,  32'h7F800000};
        vecs[4]  = '{"underflow",     32'h80800000, 32'h00800000, 5'd31, 32'h80000000};
`ifdef FMUL_PIPE_RNE_EN
        vecs[5]  = '{"round",         32'h3F800001, 32'h3FC00000, 5'd12, 32'h3FC00002};
`else
        vecs[5]  = '{"round",         32'h3F800001, 32'h3FC00000, 5'd12, 32'h3FC00001};
`endif
        vecs[6]  = '{"one_x_one",     32'h3F800000, 32'h3F800000, 5'd0,  32'h3F800000};
        vecs[7]  = '{"max_finite",    32'h7F000000, 32'h3F800000, 5'd21, 32'h7F000000};
        vecs[8]  = '{"first_inf",     32'h7F000000, 32'h40000000, 5'd22, 32'h7F800000};
        vecs[9]  = '{"min_normal",    32'h00800000, 32'h3F800000, 5'd23, 32'h00800000};
        vecs[10] = '{"e_zero_flush",  32'h00800000, 32'h3F000000, 5'd24, 32'h00000000};
        vecs[11] = '{"zero_x_inf",    32'h00000000, 32'h7F800000, 5'd25, 32'h00000000};
        vecs[12] = '{"neg_zero",      32'h80000000, 32'h3F800000, 5'd26, 32'h80000000};
        vecs[13] = '{"denorm_zero",   32'h00400000, 32'h40000000, 5'd27, 32'h00000000};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_c",     out_c, 32'd0);
        chk("reset_out_tag",   {27'd0, out_tag}, 32'd0);
        chk("reset_in_ready",  {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_one(vecs[i]);

        // Back-pressure: 4 back-to-back ops with the consumer stalled for 5 cycles
        sa = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h3F800000};
        sb = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'hBF800000};
        sc = '{32'h40C00000, 32'h40100000, 32'h40800000, 32'hBF800000};
        st = '{5'd1, 5'd2, 5'd3, 5'd4};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_fill_in_ready", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1; in_a = sa[i]; in_b = sb[i]; in_tag = st[i];
            @(posedge clk); #1;
        end
        in_a = sa[3]; in_b = sb[3]; in_tag = st[3];
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'd0, in_ready}, 32'd0);
            chk("stall_out_c",     out_c, sc[0]);
            chk("stall_out_tag",   {27'd0, out_tag}, {27'd0, st[0]});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 12 && got < 4; k++) begin
            accept_now = in_valid & in_ready;
            if (out_valid) begin
                chk("drain_c",   out_c, sc[got]);
                chk("drain_tag", {27'd0, out_tag}, {27'd0, st[got]});
                $display("drain %0d: c=%h tag=%0d (want %h tag=%0d)",
                         got, out_c, out_tag, sc[got], st[got]);
                got++;
            end
            @(posedge clk); #1;
            if (accept_now) begin
                in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
            end
        end
        chk("drain_count", got, 32'd4);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset with 2 ops in flight: neither op may ever appear on the output
        in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000; in_tag = 5'd7;
        @(posedge clk); #1;
        in_a = 32'h3FC00000; in_b = 32'h3FC00000; in_tag = 5'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rst_flushed", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        run_one(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
